mem_in_slice: RTL and testbench

- Memory-mapped input peripheral for the HACK computer. It is the read-side counterpart of the memory-mapped output register.
- Takes asynchronous external inputs (buttons/switches), synchronises and debounces them, and latches rising-edge event flags.
- Exposes two read locations to the CPU data bus: ADDRESS returns the debounced level; ADDRESS+1 returns the sticky event flags, which are write-one-to-clear.
- Raises irq while any event flag is set.

---
 rtl/mem_in_slice.sv | 86 ++++++++
 tb/tb_mem_in_slice.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_in_slice.sv
// Memory-mapped input peripheral: synchronises and debounces external pins, latches
// rising-edge event flags (write-one-to-clear) and raises irq while any flag is set.
module mem_in_slice #(
    parameter int unsigned ADDRESS    = 15'h7402,
    parameter int unsigned AW         = 15,
    parameter int unsigned DW         = 16,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic [DW-1:0] pins_in,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    input  logic          we,
    output logic [DW-1:0] data_out,
    output logic          irq
);

    localparam int unsigned   CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [AW-1:0] LVL_ADDR = AW'(ADDRESS);
    localparam logic [AW-1:0] FLG_ADDR = AW'(ADDRESS + 1);

    logic [DW-1:0] sync_q1;
    logic [DW-1:0] sync_q2;
    logic [DW-1:0] samp;
    logic [DW-1:0] level;
    logic [DW-1:0] flags;
    logic [DW-1:0] level_next;
    logic [DW-1:0] set_bits;
    logic [DW-1:0] clr_bits;
    logic [CW-1:0] count;
    logic          tick;

    assign tick = (count == CNT_LAST);

    // A bit only moves when the current tick sample matches the previous one.
    always_comb begin
        level_next = level;
        if (tick) begin
            level_next = (level & (sync_q2 ^ samp)) | (sync_q2 & ~(sync_q2 ^ samp));
        end
    end

    always_comb begin
        clr_bits = '0;
        if (we && (addr == FLG_ADDR)) begin
            clr_bits = data_in;
        end
    end

    assign set_bits = level_next & ~level;

    always_ff @(posedge clk50m) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            samp    <= '0;
            level   <= '0;
            flags   <= '0;
            count   <= '0;
        end else begin
            sync_q1 <= pins_in;
            sync_q2 <= sync_q1;
            count   <= tick ? '0 : count + 1'b1;
            if (tick) begin
                samp <= sync_q2;
            end
            level <= level_next;
            // Set is OR-ed in after the clear so a same-cycle edge is never lost.
            flags <= (flags & ~clr_bits) | set_bits;
        end
    end

    always_comb begin
        data_out = '0;
        if (addr == LVL_ADDR) begin
            data_out = level;
        end else if (addr == FLG_ADDR) begin
            data_out = flags;
        end
    end

    assign irq = |flags;

endmodule

// File: tb/tb_mem_in_slice.sv
// Bench for mem_in_slice: per-cycle expected reads queued from a history-based model,
// compared by an independent monitor, plus directed latency/W1C/collision checks.
module tb_mem_in_slice;

    localparam int          DEB = 4;
    localparam logic [14:0] A_LVL = 15'h7402;
    localparam logic [14:0] A_FLG = 15'h7403;

    logic        clk50m = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pins_in = '0;
    logic [14:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        we = 1'b0;
    logic [15:0] data_out;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;

    logic [16:0] exp_q[$];

    // Model: pin history (index 0 = last edge), last tick sample, level, flags, edges since reset
    logic [15:0] m_hist[$];
    logic [15:0] m_samp;
    logic [15:0] m_level;
    logic [15:0] m_flags;
    int          m_age;

    mem_in_slice #(
        .ADDRESS(15'h7402), .AW(15), .DW(16), .DEB_CYCLES(DEB)
    ) dut (
        .clk50m(clk50m), .rst(rst), .pins_in(pins_in), .addr(addr),
        .data_in(data_in), .we(we), .data_out(data_out), .irq(irq)
    );

    always #5 clk50m = ~clk50m;

    // Monitor: every cycle presents a read; compare against the oldest expectation.
    always @(negedge clk50m) begin
        if (exp_q.size() != 0) begin
            logic [16:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if ({irq, data_out} !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t addr=%h got irq=%b data=%h exp irq=%b data=%h",
                         $time, addr, irq, data_out, e[16], e[15:0]);
            end
        end
    end

    function automatic logic [15:0] model_read(input logic [14:0] a);
        if (a == A_LVL) return m_level;
        if (a == A_FLG) return m_flags;
        return 16'h0;
    endfunction

    task automatic model_edge(input logic [15:0] p, input logic [14:0] a, input logic w,
                              input logic [15:0] d, input logic r);
        logic [15:0] s, nl, clr;
        if (r) begin
            m_hist = {16'h0, 16'h0};
            m_samp = '0;
            m_level = '0;
            m_flags = '0;
            m_age = 0;
            return;
        end
        s = m_hist[1];
        nl = m_level;
        if (m_age % DEB == DEB - 1) begin
            for (int b = 0; b < 16; b++)
                if (s[b] == m_samp[b]) nl[b] = s[b];
            m_samp = s;
        end
        clr = (w && a == A_FLG) ? d : 16'h0;
        m_flags = (m_flags & ~clr) | (nl & ~m_level);
        m_level = nl;
        m_hist.push_front(p);
        void'(m_hist.pop_back());
        m_age++;
    endtask

    task automatic step(input logic [15:0] p, input logic [14:0] a, input logic w,
                        input logic [15:0] d, input logic r, output logic [16:0] obs);
        pins_in = p; addr = a; we = w; data_in = d; rst = r;
        exp_q.push_back({|m_flags, model_read(a)});
        @(negedge clk50m);
        obs = {irq, data_out};
        @(posedge clk50m);
        model_edge(p, a, w, d, r);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // Drive p and read the level register until it equals target; returns edges taken.
    task automatic measure(input logic [15:0] p, input logic [15:0] target, output int lat);
        logic [16:0] o;
        lat = -1;
        for (int j = 0; j < 16; j++) begin
            step(p, A_LVL, 1'b0, 16'h0, 1'b0, o);
            if (lat < 0 && o[15:0] == target) lat = j;
        end
    endtask

    initial begin
        logic [16:0] o;
        logic [15:0] acc;
        int          lat;
        int          n;
        logic [15:0] rp;
        logic [14:0] ra;

        // Reset with pins high
        pins_in = 16'hFFFF;
        rst = 1'b1;
        model_edge('0, '0, 1'b0, '0, 1'b1);
        repeat (2) @(posedge clk50m);
        #1;
        step(16'hFFFF, A_LVL, 1'b0, 16'h0, 1'b1, o);
        check("reset_level", o, 17'h0);
        step(16'hFFFF, A_FLG, 1'b0, 16'h0, 1'b1, o);
        check("reset_flags", o, 17'h0);

        // Release: level needs a full debounce
        measure(16'hFFFF, 16'hFFFF, lat);
        check("release_lat_min", lat >= 7, 1);
        check("release_lat_max", lat <= 11, 1);
        step(16'hFFFF, A_FLG, 1'b1, 16'hFFFF, 1'b0, o);
        measure(16'h0000, 16'h0000, lat);

        // Debounce 0005
        measure(16'h0005, 16'h0005, lat);
        check("deb_lat_min", lat >= 7, 1);
        check("deb_lat_max", lat <= 11, 1);
        step(16'h0005, A_FLG, 1'b0, 16'h0, 1'b0, o);
        check("deb_flags_irq", o, {1'b1, 16'h0005});

        // Glitch: 3-cycle pulse on bit 3
        acc = '0;
        for (int j = 0; j < 20; j++) begin
            step((j < 3) ? 16'h000D : 16'h0005, (j % 2) ? A_FLG : A_LVL, 1'b0, 16'h0, 1'b0, o);
            acc |= o[15:0];
        end
        check("glitch_bit3", acc[3], 1'b0);
        check("glitch_irq", o[16], 1'b1);

        // Write-one-to-clear
        step(16'h0005, A_FLG, 1'b1, 16'h0001, 1'b0, o);
        step(16'h0005, A_FLG, 1'b0, 16'h0, 1'b0, o);
        check("w1c_partial", o, {1'b1, 16'h0004});
        step(16'h0005, A_FLG, 1'b1, 16'h0004, 1'b0, o);
        step(16'h0005, A_FLG, 1'b0, 16'h0, 1'b0, o);
        check("w1c_all", o, {1'b0, 16'h0000});
        step(16'h0005, A_LVL, 1'b1, 16'hFFFF, 1'b0, o);
        step(16'h0005, A_LVL, 1'b0, 16'h0, 1'b0, o);
        check("write_level_ignored", o, {1'b0, 16'h0005});

        // Set/clear collision on bit 1: keep clearing through the rising cycle
        n = 0;
        while (m_level[1] == 1'b0 && n < 20) begin
            step(16'h0007, A_FLG, 1'b1, 16'h0002, 1'b0, o);
            n++;
        end
        check("collision_reached", n < 20, 1);
        step(16'h0007, A_FLG, 1'b0, 16'h0, 1'b0, o);
        check("collision_set_wins", o, {1'b1, 16'h0002});

        // Reset mid-debounce, two cycles after the first tick following a change
        step(16'h0007, A_FLG, 1'b1, 16'hFFFF, 1'b0, o);
        n = 0;
        do begin
            step(16'h00F0, A_LVL, 1'b0, 16'h0, 1'b0, o);
            n++;
        end while (m_age % DEB != 0 && n < 10);
        repeat (2) step(16'h00F0, A_LVL, 1'b0, 16'h0, 1'b0, o);
        repeat (2) step(16'h00F0, A_FLG, 1'b0, 16'h0, 1'b1, o);
        acc = '0;
        for (int j = 0; j < 6; j++) begin
            step(16'h00F0, (j % 2) ? A_FLG : A_LVL, 1'b0, 16'h0, 1'b0, o);
            acc |= o[15:0];
        end
        check("post_reset_quiet", acc, 16'h0);
        measure(16'h00F0, 16'h00F0, lat);
        check("post_reset_level_seen", lat >= 0, 1);
        step(16'h00F0, A_FLG, 1'b0, 16'h0, 1'b0, o);
        check("post_reset_flags", o, {1'b1, 16'h00F0});

        // Random traffic
        rp = 16'h00F0;
        n = 0;
        for (int j = 0; j < 600; j++) begin
            if (n == 0) begin
                rp = 16'($urandom);
                n = $urandom_range(1, 12);
            end
            n--;
            case ($urandom_range(0, 5))
                0, 1: ra = A_LVL;
                2, 3: ra = A_FLG;
                4: ra = 15'h7401 + 15'($urandom_range(0, 3) * 3);
                default: ra = 15'($urandom);
            endcase
            step(rp, ra, $urandom_range(0, 3) == 0, 16'($urandom),
                 $urandom_range(0, 150) == 0, o);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
